// File: rtl/perf_counter_bank_pkg.sv
// Purpose : shared defaults and encodings for the performance counter bank.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package perf_counter_bank_pkg;

  // Default bank geometry.
  localparam int DEF_CHAN_CNT = 4;
  localparam int DEF_CNT_BIT  = 32;
  localparam int DEF_SEL_BIT  = 4;

  // Saturate-mode encoding for the Saturate parameter.
  localparam int SAT_WRAP = 0;  // count wraps to 0 at max
  localparam int SAT_HOLD = 1;  // count holds at max

  // Readout channel indices used by the top-level display mux.
  typedef enum logic [3:0] {
    RD_CYC = 4'd0,  // cycles
    RD_JMP = 4'd1,  // jumps
    RD_BCH = 4'd2,  // branches
    RD_BED = 4'd3   // taken branches
  } rd_chan_e;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Purpose : control/readout bundle of the performance counter bank.
// Latency : n/a (wires only).
// Backpressure: none; the bank accepts every strobe in the cycle it is presented.
// Ports   : master drives en/inc/clr/snap/rd_sel/rd_live and observes rd_data/ovf/hit;
//           slave is the bank side.
interface perf_counter_bank_if
  import perf_counter_bank_pkg::*;
#(
  parameter int ChanCnt = DEF_CHAN_CNT,
  parameter int CntBit  = DEF_CNT_BIT,
  parameter int SelBit  = DEF_SEL_BIT
);
  logic               en;
  logic [ChanCnt-1:0] inc;
  logic               clr;
  logic               snap;
  logic [SelBit-1:0]  rd_sel;
  logic               rd_live;
  logic [CntBit-1:0]  rd_data;
  logic [ChanCnt-1:0] ovf;
  logic [ChanCnt-1:0] hit;

  modport master (
    output en, inc, clr, snap, rd_sel, rd_live,
    input  rd_data, ovf, hit
  );

  modport slave (
    input  en, inc, clr, snap, rd_sel, rd_live,
    output rd_data, ovf, hit
  );
endinterface

// File: rtl/perf_counter_bank_cell.sv
// Purpose : one counter channel: count, snapshot, sticky overflow, threshold hit pulse.
// Latency : all outputs registered, updated on the edge that samples the strobes.
// Backpressure: none; an increment is taken every cycle en && inc is high.
// Ports   : clk/rst, en/inc/clr/snap strobes in; cnt, snapshot, ovf, hit out.
module perf_counter_cell
  import perf_counter_bank_pkg::*;
#(
  parameter int CntBit    = DEF_CNT_BIT,
  parameter int Saturate  = SAT_WRAP,
  parameter int Threshold = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              inc,
  input  logic              clr,
  input  logic              snap,
  output logic [CntBit-1:0] cnt,
  output logic [CntBit-1:0] snapshot,
  output logic              ovf,
  output logic              hit
);

  localparam bit              HOLD = (Saturate == SAT_HOLD);
  localparam logic [CntBit-1:0] THR = CntBit'(Threshold);

  logic              at_max;
  logic [CntBit-1:0] cnt_inc;
  logic [CntBit-1:0] cnt_step;
  logic              hit_step;

  always_comb begin
    at_max   = &cnt;
    cnt_inc  = cnt + CntBit'(1);
    cnt_step = cnt_inc;
    if (at_max && HOLD) begin
      cnt_step = cnt;
    end
    // A hit needs the value to actually change into THR; at max the value
    // either wraps to 0 (never a live threshold) or holds (no re-fire).
    hit_step = (Threshold != 0) && !at_max && (cnt_inc == THR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      snapshot <= '0;
      ovf      <= 1'b0;
      hit      <= 1'b0;
    end else begin
      // Snapshot sees the value registered at the start of the cycle,
      // independent of any clear or increment landing on the same edge.
      if (snap) begin
        snapshot <= cnt;
      end
      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
        hit <= 1'b0;
      end else if (en && inc) begin
        cnt <= cnt_step;
        hit <= hit_step;
        if (at_max) begin
          ovf <= 1'b1;
        end
      end else begin
        hit <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Purpose : bank of ChanCnt event counters with snapshot and selectable registered readout.
// Latency : rd_data one cycle after rd_sel/rd_live; ovf/hit registered in the cells.
// Backpressure: none; strobes are consumed every cycle, readout is free-running.
// Ports   : clk/rst plain; bus (slave) carries en/inc/clr/snap/rd_sel/rd_live in and
//           rd_data/ovf/hit out.
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int ChanCnt   = DEF_CHAN_CNT,
  parameter int CntBit    = DEF_CNT_BIT,
  parameter int SelBit    = DEF_SEL_BIT,
  parameter int Saturate  = SAT_WRAP,
  parameter int Threshold = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  perf_counter_bank_if.slave   bus
);

  logic [CntBit-1:0]  cnt_arr  [ChanCnt];
  logic [CntBit-1:0]  snap_arr [ChanCnt];
  logic [ChanCnt-1:0] ovf_vec;
  logic [ChanCnt-1:0] hit_vec;
  logic [CntBit-1:0]  rd_mux;

  for (genvar g = 0; g < ChanCnt; g++) begin : g_cell
    perf_counter_cell #(
      .CntBit    (CntBit),
      .Saturate  (Saturate),
      .Threshold (Threshold)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .inc      (bus.inc[g]),
      .clr      (bus.clr),
      .snap     (bus.snap),
      .cnt      (cnt_arr[g]),
      .snapshot (snap_arr[g]),
      .ovf      (ovf_vec[g]),
      .hit      (hit_vec[g])
    );
  end

  assign bus.ovf = ovf_vec;
  assign bus.hit = hit_vec;

  // Selects beyond the populated channels fall through to 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < ChanCnt; i++) begin
      if (bus.rd_sel == SelBit'(i)) begin
        rd_mux = bus.rd_live ? cnt_arr[i] : snap_arr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data <= '0;
    end else begin
      bus.rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
  import perf_counter_bank_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // b0: 32-bit wrap, no threshold. b1: 4-bit wrap. b2: 4-bit saturate.
  // b3: 4-bit wrap with Threshold=5.
  perf_counter_bank_if #(.ChanCnt(4), .CntBit(32), .SelBit(4)) b0 ();
  perf_counter_bank_if #(.ChanCnt(4), .CntBit(4),  .SelBit(4)) b1 ();
  perf_counter_bank_if #(.ChanCnt(4), .CntBit(4),  .SelBit(4)) b2 ();
  perf_counter_bank_if #(.ChanCnt(4), .CntBit(4),  .SelBit(4)) b3 ();

  perf_counter_bank #(.ChanCnt(4), .CntBit(32), .SelBit(4), .Saturate(SAT_WRAP), .Threshold(0))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  perf_counter_bank #(.ChanCnt(4), .CntBit(4), .SelBit(4), .Saturate(SAT_WRAP), .Threshold(0))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  perf_counter_bank #(.ChanCnt(4), .CntBit(4), .SelBit(4), .Saturate(SAT_HOLD), .Threshold(0))
    u2 (.clk(clk), .rst(rst), .bus(b2));
  perf_counter_bank #(.ChanCnt(4), .CntBit(4), .SelBit(4), .Saturate(SAT_WRAP), .Threshold(5))
    u3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Quiet defaults on every bus.
    b0.en = 0; b0.inc = '0; b0.clr = 0; b0.snap = 0; b0.rd_sel = '0; b0.rd_live = 0;
    b1.en = 0; b1.inc = '0; b1.clr = 0; b1.snap = 0; b1.rd_sel = '0; b1.rd_live = 0;
    b2.en = 0; b2.inc = '0; b2.clr = 0; b2.snap = 0; b2.rd_sel = '0; b2.rd_live = 0;
    b3.en = 0; b3.inc = '0; b3.clr = 0; b3.snap = 0; b3.rd_sel = '0; b3.rd_live = 0;

    // 1. Reset with every strobe active.
    rst = 1; b0.en = 1; b0.inc = 4'hF;
    tick(2);
    chk("rst_rd_data", b0.rd_data, 32'd0);
    chk("rst_ovf", 32'(b0.ovf), 32'd0);
    chk("rst_hit", 32'(b0.hit), 32'd0);
    rst = 0; b0.en = 0; b0.inc = '0; b0.rd_live = 1;
    for (int i = 0; i < 4; i++) begin
      b0.rd_sel = 4'(i);
      tick();
      chk($sformatf("rst_live_ch%0d", i), b0.rd_data, 32'd0);
    end

    // 2. Count channels 0 and 2 ten times, snapshot, read back.
    b0.en = 1; b0.inc = 4'b0101;
    tick(10);
    b0.en = 0; b0.inc = '0;
    b0.snap = 1; b0.rd_live = 0; b0.rd_sel = RD_BCH;
    tick();
    b0.snap = 0;
    tick();
    chk("snap_ch2", b0.rd_data, 32'd10);
    b0.rd_sel = 4'd0; tick(); chk("snap_ch0", b0.rd_data, 32'd10);
    b0.rd_sel = 4'd1; tick(); chk("snap_ch1", b0.rd_data, 32'd0);
    b0.rd_sel = 4'd3; tick(); chk("snap_ch3", b0.rd_data, 32'd0);
    b0.rd_sel = 4'd5; tick(); chk("sel_out_of_range", b0.rd_data, 32'd0);
    b0.rd_live = 1; b0.rd_sel = 4'd2; tick(); chk("live_ch2", b0.rd_data, 32'd10);
    chk("thr0_no_hit", 32'(b0.hit), 32'd0);
    chk("no_ovf_b0", 32'(b0.ovf), 32'd0);

    // 3. Wrap mode: 16 increments on channel 0.
    b1.en = 1; b1.inc = 4'b0001;
    tick(15);
    chk("wrap_ovf_before", 32'(b1.ovf[0]), 32'd0);
    tick();
    chk("wrap_ovf_set", 32'(b1.ovf[0]), 32'd1);
    b1.en = 0; b1.rd_live = 1; b1.rd_sel = 4'd0;
    tick();
    chk("wrap_cnt_zero", 32'(b1.rd_data), 32'd0);
    b1.en = 1;
    tick(3);
    b1.en = 0;
    tick();
    chk("wrap_cnt_3", 32'(b1.rd_data), 32'd3);
    chk("wrap_ovf_sticky", 32'(b1.ovf[0]), 32'd1);
    b1.clr = 1;
    tick();
    b1.clr = 0;
    chk("wrap_clr_ovf", 32'(b1.ovf[0]), 32'd0);
    tick();
    chk("wrap_clr_cnt", 32'(b1.rd_data), 32'd0);

    // 4. Saturate mode: 20 increments hold at 15.
    b2.en = 1; b2.inc = 4'b0001;
    tick(15);
    chk("sat_ovf_before", 32'(b2.ovf[0]), 32'd0);
    tick(5);
    chk("sat_ovf_set", 32'(b2.ovf[0]), 32'd1);
    b2.en = 0; b2.rd_live = 1; b2.rd_sel = 4'd0;
    tick();
    chk("sat_cnt_15", 32'(b2.rd_data), 32'd15);

    // 5. Threshold=5: hit on the 5th increment, frozen while en=0, re-fires on the 21st.
    b3.en = 1; b3.inc = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("thr_hit_inc%0d", k), 32'(b3.hit[0]), (k == 5) ? 32'd1 : 32'd0);
    end
    b3.en = 0; b3.rd_live = 1; b3.rd_sel = 4'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("thr_en0_hit%0d", k), 32'(b3.hit[0]), 32'd0);
      chk($sformatf("thr_en0_cnt%0d", k), 32'(b3.rd_data), 32'd5);
    end
    b3.en = 1;
    for (int k = 6; k <= 21; k++) begin
      tick();
      chk($sformatf("thr_hit_inc%0d", k), 32'(b3.hit[0]), (k == 21) ? 32'd1 : 32'd0);
    end
    chk("thr_ovf_after_wrap", 32'(b3.ovf[0]), 32'd1);
    chk("thr_other_ch_no_hit", 32'(b3.hit[3:1]), 32'd0);
    b3.en = 0;

    // 6. Simultaneous clr+snap+inc at count 7.
    b0.clr = 1; tick(); b0.clr = 0;
    b0.en = 1; b0.inc = 4'b0001;
    tick(7);
    b0.clr = 1; b0.snap = 1; b0.rd_live = 1; b0.rd_sel = 4'd0;
    tick();
    chk("simul_live_read", b0.rd_data, 32'd7);
    b0.clr = 0; b0.snap = 0; b0.en = 0; b0.inc = '0; b0.rd_live = 0;
    tick();
    chk("simul_snapshot", b0.rd_data, 32'd7);
    b0.rd_live = 1;
    tick();
    chk("simul_cnt_zero", b0.rd_data, 32'd0);
    chk("simul_ovf", 32'(b0.ovf[0]), 32'd0);

    // 7. Reset mid-count: counting restarts from 0, snapshot lost.
    b0.en = 1; b0.inc = 4'b0001;
    tick(3);
    rst = 1; tick(); rst = 0;
    tick();
    b0.en = 0; b0.rd_live = 1; b0.rd_sel = 4'd0;
    tick();
    chk("rst_mid_cnt", b0.rd_data, 32'd1);
    b0.rd_live = 0;
    tick();
    chk("rst_mid_snapshot", b0.rd_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
